transpose_buf: RTL and testbench

Parametrised N×N transpose buffer for the JPEG forward-DCT datapath, placed between the row-DCT and column-DCT passes. It accepts one row of N signed W-bit coefficients per write strobe and returns one column per read strobe. With double buffering compiled in, it writes one block while the previous block is read out, so the 2-D DCT streams with no stall.

---
 rtl/transpose_pkg.sv | 14 +
 rtl/transpose_buf_if.sv | 20 ++
 rtl/transpose_bank.sv | 36 +++
 rtl/transpose_buf.sv | 101 ++++++++++
 tb/tb_transpose_buf.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/transpose_pkg.sv
// Shared constants and bank bookkeeping type for the DCT transpose buffer.
package transpose_pkg;

  localparam int TRANSPOSE_N_DEF = 8;
  localparam int TRANSPOSE_W_DEF = 12;

  // Full flag per bank plus the write and read bank pointers.
  typedef struct packed {
    logic [1:0] full;
    logic       wbank;
    logic       rbank;
  } bank_state_t;

endpackage

// File: rtl/transpose_buf_if.sv
// Row-in / column-out handshake bundle for transpose_buf.
interface transpose_buf_if
  import transpose_pkg::*;
#(
  parameter int N = TRANSPOSE_N_DEF,
  parameter int W = TRANSPOSE_W_DEF
);

  logic           wr;
  logic [N*W-1:0] in;
  logic           rd;
  logic [N*W-1:0] ut;
  logic           wr_ready;
  logic           rd_valid;
  logic           err;

  modport master (output wr, in, rd, input ut, wr_ready, rd_valid, err);
  modport slave  (input wr, in, rd, output ut, wr_ready, rd_valid, err);

endinterface

// File: rtl/transpose_bank.sv
// One N x N element register array: row-wide write, column-wide read.
// Contents are deliberately not reset.
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int N = TRANSPOSE_N_DEF,
  parameter int W = TRANSPOSE_W_DEF
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] wrow,
  input  logic [N*W-1:0]       wdata,
  input  logic [$clog2(N)-1:0] rcol,
  output logic [N*W-1:0]       rdata
);

  logic [W-1:0] mem [N][N];

  // Store the incoming row, element 0 taken from the MSBs.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < N; c++) begin
        mem[wrow][c] <= wdata[W*(N-c)-1 -: W];
      end
    end
  end

  // Gather column rcol, row j of the array landing in element slot j.
  always_comb begin
    rdata = '0;
    for (int j = 0; j < N; j++) begin
      rdata[W*(N-j)-1 -: W] = mem[j][rcol];
    end
  end

endmodule

// File: rtl/transpose_buf.sv
// N x N transpose buffer between the row-DCT and column-DCT passes.
// Define TRANSPOSE_PINGPONG_EN for two banks (write one block while the
// previous one drains); otherwise a single bank alternates fill/drain.
module transpose_buf
  import transpose_pkg::*;
#(
  parameter int N = TRANSPOSE_N_DEF,
  parameter int W = TRANSPOSE_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  transpose_buf_if.slave bus
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  bank_state_t    st;
  logic [1:0]     full_nxt;
  logic [CW-1:0]  wrow;
  logic [CW-1:0]  rcol;
  logic           wr_ok;
  logic           rd_ok;
  logic           wr_last;
  logic           rd_last;
  logic [N*W-1:0] rd_word;

  assign bus.wr_ready = !st.full[st.wbank];
  assign bus.rd_valid = st.full[st.rbank];

  assign wr_ok   = bus.wr && bus.wr_ready;
  assign rd_ok   = bus.rd && bus.rd_valid;
  assign wr_last = wr_ok && (wrow == LAST);
  assign rd_last = rd_ok && (rcol == LAST);

`ifdef TRANSPOSE_PINGPONG_EN
  logic [N*W-1:0] rdata0;
  logic [N*W-1:0] rdata1;

  transpose_bank #(.N(N), .W(W)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok && !st.wbank),
    .wrow  (wrow),
    .wdata (bus.in),
    .rcol  (rcol),
    .rdata (rdata0)
  );

  transpose_bank #(.N(N), .W(W)) u_bank1 (
    .clk   (clk),
    .we    (wr_ok && st.wbank),
    .wrow  (wrow),
    .wdata (bus.in),
    .rcol  (rcol),
    .rdata (rdata1)
  );

  assign rd_word = st.rbank ? rdata1 : rdata0;
`else
  transpose_bank #(.N(N), .W(W)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok),
    .wrow  (wrow),
    .wdata (bus.in),
    .rcol  (rcol),
    .rdata (rd_word)
  );
`endif

  assign bus.ut = bus.rd_valid ? rd_word : '0;

  // Completion of a fill sets its bank's flag; completion of a drain clears
  // its own. With two banks these never target the same bank in one cycle.
  always_comb begin
    full_nxt = st.full;
    if (wr_last) full_nxt[st.wbank] = 1'b1;
    if (rd_last) full_nxt[st.rbank] = 1'b0;
  end

  // Row/column counters, bank pointers, full flags and the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= '0;
      wrow    <= '0;
      rcol    <= '0;
      bus.err <= 1'b0;
    end else begin
      st.full <= full_nxt;
      if (wr_ok) wrow <= wr_last ? '0 : wrow + CW'(1);
      if (rd_ok) rcol <= rd_last ? '0 : rcol + CW'(1);
`ifdef TRANSPOSE_PINGPONG_EN
      if (wr_last) st.wbank <= !st.wbank;
      if (rd_last) st.rbank <= !st.rbank;
`endif
      if ((bus.wr && !bus.wr_ready) || (bus.rd && !bus.rd_valid)) begin
        bus.err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_transpose_buf.sv
// Directed bench for transpose_buf: an 8x12 instance driven by a vector
// table and hand-written sequences, plus a 4x16 instance for the basic case.
module tb_transpose_buf;

`ifdef TRANSPOSE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  transpose_buf_if #(.N(8), .W(12)) b1 ();
  transpose_buf_if #(.N(4), .W(16)) b2 ();

  transpose_buf #(.N(8), .W(12)) u_dut8 (.clk(clk), .rst(rst), .bus(b1.slave));
  transpose_buf #(.N(4), .W(16)) u_dut4 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct {
    logic        wr;
    logic        rd;
    logic [95:0] din;
    logic        exp_ready;
    logic        exp_valid;
    logic [95:0] exp_ut;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  // Pattern 0: r*8+c, 1: 64+r*8+c, 2: 0x800/0x7FF checkerboard, 3: filler.
  function automatic logic [11:0] el(int pat, int r, int c);
    case (pat)
      0:       el = 12'(r*8 + c);
      1:       el = 12'(64 + r*8 + c);
      2:       el = ((r + c) % 2 == 0) ? 12'h800 : 12'h7FF;
      default: el = 12'(4095 - (r*8 + c));
    endcase
  endfunction

  function automatic logic [95:0] row(int pat, int r);
    logic [95:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[95-12*c -: 12] = el(pat, r, c);
    return v;
  endfunction

  function automatic logic [95:0] col(int pat, int c);
    logic [95:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[95-12*j -: 12] = el(pat, j, c);
    return v;
  endfunction

  function automatic logic [15:0] el4(int r, int c);
    return 16'(16'hC000 + r*4 + c);
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_blk(int pat);
    for (int r = 0; r < 8; r++) begin
      b1.wr = 1'b1;
      b1.in = row(pat, r);
      tick();
    end
    b1.wr = 1'b0;
  endtask

  task automatic read_blk(int pat, string tag);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("%s valid c%0d", tag, c), 128'(b1.rd_valid), 128'(1));
      chk($sformatf("%s ut c%0d", tag, c), 128'(b1.ut), 128'(col(pat, c)));
      b1.rd = 1'b1;
      tick();
    end
    b1.rd = 1'b0;
  endtask

  initial begin
    b1.wr = 1'b0; b1.rd = 1'b0; b1.in = '0;
    b2.wr = 1'b0; b2.rd = 1'b0; b2.in = '0;

    for (int k = 0; k < 16; k++) begin
      if (k < 8) begin
        vecs[k].wr        = 1'b1;
        vecs[k].rd        = 1'b0;
        vecs[k].din       = row(0, k);
        vecs[k].exp_ready = (k == 7) ? PP : 1'b1;
        vecs[k].exp_valid = (k == 7);
        vecs[k].exp_ut    = (k == 7) ? col(0, 0) : '0;
      end else begin
        vecs[k].wr        = 1'b0;
        vecs[k].rd        = 1'b1;
        vecs[k].din       = '0;
        vecs[k].exp_ready = (k == 15) ? 1'b1 : PP;
        vecs[k].exp_valid = (k < 15);
        vecs[k].exp_ut    = (k < 15) ? col(0, k - 7) : '0;
      end
      vecs[k].exp_err = 1'b0;
    end

    tick();
    tick();
    rst = 1'b0;

    chk("reset wr_ready", 128'(b1.wr_ready), 128'(1));
    chk("reset rd_valid", 128'(b1.rd_valid), 128'(0));
    chk("reset ut", 128'(b1.ut), 128'(0));
    chk("reset err", 128'(b1.err), 128'(0));
    chk("reset4 wr_ready", 128'(b2.wr_ready), 128'(1));
    chk("reset4 rd_valid", 128'(b2.rd_valid), 128'(0));

    b1.rd = 1'b1;
    tick();
    b1.rd = 1'b0;
    chk("early rd err", 128'(b1.err), 128'(1));
    chk("early rd ut", 128'(b1.ut), 128'(0));
    chk("early rd rd_valid", 128'(b1.rd_valid), 128'(0));
    tick();
    chk("err sticky", 128'(b1.err), 128'(1));
    do_reset();
    chk("err cleared by rst", 128'(b1.err), 128'(0));

    for (int k = 0; k < 16; k++) begin
      b1.wr = vecs[k].wr;
      b1.rd = vecs[k].rd;
      b1.in = vecs[k].din;
      tick();
      chk($sformatf("vec%0d wr_ready", k), 128'(b1.wr_ready), 128'(vecs[k].exp_ready));
      chk($sformatf("vec%0d rd_valid", k), 128'(b1.rd_valid), 128'(vecs[k].exp_valid));
      chk($sformatf("vec%0d ut", k), 128'(b1.ut), 128'(vecs[k].exp_ut));
      chk($sformatf("vec%0d err", k), 128'(b1.err), 128'(vecs[k].exp_err));
    end
    b1.wr = 1'b0;
    b1.rd = 1'b0;

    do_reset();
`ifdef TRANSPOSE_PINGPONG_EN
    for (int t = 0; t < 24; t++) begin
      if (t < 16) chk($sformatf("stream t%0d wr_ready", t), 128'(b1.wr_ready), 128'(1));
      if (t >= 8) begin
        chk($sformatf("stream t%0d rd_valid", t), 128'(b1.rd_valid), 128'(1));
        chk($sformatf("stream t%0d ut", t), 128'(b1.ut), 128'(col((t < 16) ? 0 : 1, (t - 8) % 8)));
      end
      b1.wr = (t < 16);
      b1.in = row((t < 8) ? 0 : 1, t % 8);
      b1.rd = (t >= 8);
      tick();
    end
`else
    for (int t = 0; t < 32; t++) begin
      if (t >= 8 && t < 16) begin
        chk($sformatf("serial t%0d wr_ready", t), 128'(b1.wr_ready), 128'(0));
        chk($sformatf("serial t%0d ut", t), 128'(b1.ut), 128'(col(0, t - 8)));
      end
      if (t >= 16 && t < 24) begin
        chk($sformatf("serial t%0d wr_ready", t), 128'(b1.wr_ready), 128'(1));
        chk($sformatf("serial t%0d rd_valid", t), 128'(b1.rd_valid), 128'(0));
      end
      if (t >= 24) begin
        chk($sformatf("serial t%0d wr_ready", t), 128'(b1.wr_ready), 128'(0));
        chk($sformatf("serial t%0d ut", t), 128'(b1.ut), 128'(col(1, t - 24)));
      end
      b1.wr = (t < 8) || (t >= 16 && t < 24);
      b1.in = row((t < 8) ? 0 : 1, t % 8);
      b1.rd = (t >= 8 && t < 16) || (t >= 24);
      tick();
    end
`endif
    b1.wr = 1'b0;
    b1.rd = 1'b0;
    chk("stream end rd_valid", 128'(b1.rd_valid), 128'(0));
    chk("stream end err", 128'(b1.err), 128'(0));

    do_reset();
    write_blk(0);
`ifdef TRANSPOSE_PINGPONG_EN
    write_blk(1);
`endif
    b1.wr = 1'b1;
    b1.in = row(3, 0);
    tick();
    b1.wr = 1'b0;
    chk("overflow err", 128'(b1.err), 128'(1));
    chk("overflow wr_ready", 128'(b1.wr_ready), 128'(0));
    read_blk(0, "overflow blk0");
`ifdef TRANSPOSE_PINGPONG_EN
    read_blk(1, "overflow blk1");
`endif
    chk("overflow drained", 128'(b1.rd_valid), 128'(0));

    do_reset();
    for (int r = 0; r < 3; r++) begin
      b1.wr = 1'b1;
      b1.in = row(3, r);
      tick();
    end
    b1.wr = 1'b0;
    do_reset();
    chk("midrst wr_ready", 128'(b1.wr_ready), 128'(1));
    chk("midrst rd_valid", 128'(b1.rd_valid), 128'(0));
    chk("midrst err", 128'(b1.err), 128'(0));
    chk("midrst ut", 128'(b1.ut), 128'(0));
    write_blk(0);
    read_blk(0, "midrst");
    chk("midrst drained", 128'(b1.rd_valid), 128'(0));

    write_blk(2);
    read_blk(2, "checker");

    for (int r = 0; r < 4; r++) begin
      b2.wr = 1'b1;
      for (int c = 0; c < 4; c++) b2.in[63-16*c -: 16] = el4(r, c);
      tick();
    end
    b2.wr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      logic [63:0] exp4;
      for (int j = 0; j < 4; j++) exp4[63-16*j -: 16] = el4(j, c);
      chk($sformatf("n4 valid c%0d", c), 128'(b2.rd_valid), 128'(1));
      chk($sformatf("n4 ut c%0d", c), 128'(b2.ut), 128'(exp4));
      b2.rd = 1'b1;
      tick();
    end
    b2.rd = 1'b0;
    chk("n4 drained", 128'(b2.rd_valid), 128'(0));
    chk("n4 err", 128'(b2.err), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
